// File: rtl/mul_gate_pkg.sv
// Shared constants for the gate-level Q0.N multiplier.
// Build macro MUL_GATE_ROUND_EN selects round-half-up reduction of the Q0.2N product.
package mul_gate_pkg;

    localparam int MUL_GATE_N_DEFAULT = 16;

    typedef enum logic {
        REDUCE_TRUNC = 1'b0,
        REDUCE_ROUND = 1'b1
    } reduce_mode_e;

`ifdef MUL_GATE_ROUND_EN
    localparam reduce_mode_e REDUCE_MODE = REDUCE_ROUND;
`else
    localparam reduce_mode_e REDUCE_MODE = REDUCE_TRUNC;
`endif

    // Q0.N x Q0.N yields Q0.2N: fractional bit count of the full product.
    function automatic int q_prod_bits(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/mul_gate_fa_cell.sv
// Full adder built from AND/XOR/OR gates; tie cin to 0 to use it as a half adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign s    = ab_x ^ cin;
    assign cout = (a & b) | (cin & ab_x);

endmodule

// File: rtl/mul_gate.sv
// Unsigned Q0.N x Q0.N array multiplier from AND partial products and fa_cell rows, plus a capture register.
// Defining MUL_GATE_ROUND_EN makes p_hi_q round half up (with clamp) instead of truncating.
module mul_gate
    import mul_gate_pkg::*;
#(
    parameter int N = MUL_GATE_N_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [N-1:0]                  a,
    input  logic [N-1:0]                  b,
    output logic [q_prod_bits(N)-1:0]     p,
    output logic [q_prod_bits(N)-1:0]     p_q,
    output logic [N-1:0]                  p_hi_q,
    output logic                          out_valid
);

    localparam int PW = q_prod_bits(N);

    logic [N-1:0] pp      [N];
    logic [N-1:0] row_sum [N];
    logic         row_co  [N];

    for (genvar i = 0; i < N; i++) begin : g_pp
        for (genvar j = 0; j < N; j++) begin : g_pp_bit
            assign pp[i][j] = a[j] & b[i];
        end
    end

    assign row_sum[0] = pp[0];
    assign row_co[0]  = 1'b0;

    // Each row adds the previous row's shifted-down sum (carry as new MSB) to the next partial product;
    // the bit falling off the bottom of each row is a finished product bit.
    for (genvar i = 1; i < N; i++) begin : g_row
        logic [N-1:0] x;
        logic [N:0]   c;

        assign x    = {row_co[i-1], row_sum[i-1][N-1:1]};
        assign c[0] = 1'b0;

        for (genvar j = 0; j < N; j++) begin : g_cell
            fa_cell u_fa (
                .a    (x[j]),
                .b    (pp[i][j]),
                .cin  (c[j]),
                .s    (row_sum[i][j]),
                .cout (c[j+1])
            );
        end

        assign row_co[i] = c[N];
    end

    for (genvar i = 0; i < N; i++) begin : g_plo
        assign p[i] = row_sum[i][0];
    end
    assign p[PW-1:N] = {row_co[N-1], row_sum[N-1][N-1:1]};

    logic [N:0]    hi_sum;
    logic [N-1:0]  p_hi_red;
    logic [PW-1:0] p_d;
    logic [N-1:0]  p_hi_d;
    logic          valid_d;
    logic          valid_q;

    // Carry-out of the rounding add cannot happen for Q0.N operands, but saturate regardless.
    always_comb begin
        hi_sum   = {1'b0, p[PW-1:N]} + {{N{1'b0}}, p[N-1]};
        p_hi_red = p[PW-1:N];
        if (REDUCE_MODE == REDUCE_ROUND) begin
            p_hi_red = hi_sum[N] ? {N{1'b1}} : hi_sum[N-1:0];
        end
    end

    always_comb begin
        p_d     = p_q;
        p_hi_d  = p_hi_q;
        valid_d = 1'b0;
        if (in_valid) begin
            p_d     = p;
            p_hi_d  = p_hi_red;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            p_hi_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            p_hi_q  <= p_hi_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_mul_gate.sv
// Directed-vector and random-sweep bench for mul_gate (N=16); honours MUL_GATE_ROUND_EN for p_hi_q.
module tb_mul_gate;

    localparam int N = 16;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    logic [2*N-1:0] p_q;
    logic [N-1:0]   p_hi_q;
    logic           out_valid;

    int num_vectors = 0;
    int num_miscompares = 0;

    mul_gate #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .p         (p),
        .p_q       (p_q),
        .p_hi_q    (p_hi_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        logic [N-1:0]   hi_trunc;
        logic [N-1:0]   hi_round;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_vectors++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic v, input logic r);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = v;
        rst      = r;
    endtask

    function automatic logic [N-1:0] pickHi(input vec_t v);
`ifdef MUL_GATE_ROUND_EN
        return v.hi_round;
`else
        return v.hi_trunc;
`endif
    endfunction

    logic [2*N-1:0] exp_p;
    logic [2*N-1:0] prev_p;
    logic [N-1:0]   held_hi;

    initial begin
        vecs[0]  = '{16'h7893, 16'hA6E9, 32'h4E9D0FCB, 16'h4E9D, 16'h4E9D};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'hFFFE, 16'hFFFE};
        vecs[2]  = '{16'h0001, 16'h8000, 32'h00008000, 16'h0000, 16'h0001};
        vecs[3]  = '{16'h8000, 16'h8000, 32'h40000000, 16'h4000, 16'h4000};
        vecs[4]  = '{16'h0000, 16'h1234, 32'h00000000, 16'h0000, 16'h0000};
        vecs[5]  = '{16'h1234, 16'h0000, 32'h00000000, 16'h0000, 16'h0000};
        vecs[6]  = '{16'h0001, 16'h0001, 32'h00000001, 16'h0000, 16'h0000};
        vecs[7]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 16'h0000, 16'h0001};
        vecs[8]  = '{16'h8000, 16'h0002, 32'h00010000, 16'h0001, 16'h0001};
        vecs[9]  = '{16'h1234, 16'h5678, 32'h06260060, 16'h0626, 16'h0626};
        vecs[10] = '{16'hFFFF, 16'h8000, 32'h7FFF8000, 16'h7FFF, 16'h8000};
        vecs[11] = '{16'h0000, 16'hFFFF, 32'h00000000, 16'h0000, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset p_q", 64'(p_q), 64'd0);
        checkOutput("reset p_hi_q", 64'(p_hi_q), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d p", i), 64'(p), 64'(vecs[i].p));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d p_q", i), 64'(p_q), 64'(vecs[i].p));
            checkOutput($sformatf("vec%0d p_hi_q", i), 64'(p_hi_q), 64'(pickHi(vecs[i])));
            checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
        end

        // Hold: in_valid low drops out_valid while the last result stays put.
        applyStimulus(vecs[1].a, vecs[1].b, 1'b1, 1'b0);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("hold out_valid", 64'(out_valid), 64'd0);
        checkOutput("hold p_q", 64'(p_q), 64'(vecs[1].p));
        checkOutput("hold p_hi_q", 64'(p_hi_q), 64'(pickHi(vecs[1])));

        // Reset dominates in_valid for two cycles; p stays combinational.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'h7893, 16'hA6E9, 1'b1, 1'b1);
            #1;
            checkOutput("rst p comb", 64'(p), 64'h4E9D0FCB);
            @(posedge clk);
            #1;
            checkOutput("rst p_q", 64'(p_q), 64'd0);
            checkOutput("rst p_hi_q", 64'(p_hi_q), 64'd0);
            checkOutput("rst out_valid", 64'(out_valid), 64'd0);
        end
        applyStimulus(16'h7893, 16'hA6E9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post-rst idle out_valid", 64'(out_valid), 64'd0);
        checkOutput("post-rst idle p_q", 64'(p_q), 64'd0);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post-rst first out_valid", 64'(out_valid), 64'd1);
        checkOutput("post-rst first p_q", 64'(p_q), 64'h40000000);

        // Mid-stream reset discards the capture of that cycle.
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("midrst out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst p_q", 64'(p_q), 64'd0);
        held_hi = p_hi_q;
        checkOutput("midrst p_hi_q", 64'(held_hi), 64'd0);

        // Back-to-back random pairs: p checked immediately, p_q one cycle later.
        prev_p = '0;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'b1, 1'b0);
            exp_p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            #1;
            checkOutput("rand p", 64'(p), 64'(exp_p));
            if (i > 0) begin
                checkOutput("rand p_q", 64'(p_q), 64'(prev_p));
            end
            prev_p = exp_p;
        end
        @(posedge clk);
        #1;
        checkOutput("rand last p_q", 64'(p_q), 64'(prev_p));

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
